// File: rtl/comparador_decodificador_param_if.sv
// Bus bundle for comparador_decodificador_param: threshold load, sample stream,
// compare mode, decoder select and all registered results.
interface comparador_decodificador_param_if #(
   parameter int WIDTH     = 6,
   parameter int SEL_BITS  = 3,
   parameter int CNT_WIDTH = 8
);
   localparam int DEC_W = 1 << SEL_BITS;

   logic                 LoadThreshold;
   logic [WIDTH-1:0]     ThresholdIn;
   logic [WIDTH-1:0]     Sample;
   logic                 SampleValid;
   logic [1:0]           Mode;
   logic [SEL_BITS-1:0]  Sel;
   logic                 Enable;
   logic                 MatchRaw;
   logic                 Match;
   logic [CNT_WIDTH-1:0] MatchCount;
   logic [DEC_W-1:0]     Decoded;

   // The stimulus source drives the request side and observes the results
   modport master (
      output LoadThreshold, ThresholdIn, Sample, SampleValid, Mode, Sel, Enable,
      input  MatchRaw, Match, MatchCount, Decoded
   );

   modport slave (
      input  LoadThreshold, ThresholdIn, Sample, SampleValid, Mode, Sel, Enable,
      output MatchRaw, Match, MatchCount, Decoded
   );
endinterface

// File: rtl/comparador_decodificador_param.sv
// Programmable-threshold comparator with debounce and saturating event counter,
// plus a registered one-hot decoder with enable.
module comparador_decodificador_param #(
   parameter int WIDTH          = 6,
   parameter int THRESH_DEFAULT = 22,
   parameter int DEBOUNCE       = 4,
   parameter int SEL_BITS       = 3,
   parameter int CNT_WIDTH      = 8
) (
   input logic                          Clock,
   input logic                          Reset,
   comparador_decodificador_param_if.slave bus
);
   localparam int DEC_W    = 1 << SEL_BITS;
   localparam int STREAK_W = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);

   localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(DEBOUNCE);
   localparam logic [WIDTH-1:0]     THR_RESET  = WIDTH'(THRESH_DEFAULT);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

   localparam logic [1:0] MODE_EQ = 2'b00;
   localparam logic [1:0] MODE_GT = 2'b01;
   localparam logic [1:0] MODE_LT = 2'b10;
   localparam logic [1:0] MODE_GE = 2'b11;

   logic [WIDTH-1:0]     thresholdQ, thresholdD;
   logic [STREAK_W-1:0]  streakQ, streakD;
   logic                 matchRawQ, matchRawD;
   logic                 matchQ, matchD;
   logic [CNT_WIDTH-1:0] countQ, countD;
   logic [DEC_W-1:0]     decodedQ, decodedD;
   logic                 compareHit;

   // Unsigned compare of the current sample against the threshold in force this cycle
   always_comb begin
      compareHit = 1'b0;
      case (bus.Mode)
         MODE_EQ: compareHit = (bus.Sample == thresholdQ);
         MODE_GT: compareHit = (bus.Sample >  thresholdQ);
         MODE_LT: compareHit = (bus.Sample <  thresholdQ);
         MODE_GE: compareHit = (bus.Sample >= thresholdQ);
         default: compareHit = 1'b0;
      endcase
   end

   // Threshold, raw result and debounce streak; a threshold load restarts the streak
   always_comb begin
      thresholdD = thresholdQ;
      matchRawD  = matchRawQ;
      streakD    = streakQ;
      matchD     = matchQ;

      if (bus.SampleValid) begin
         matchRawD = compareHit;
         if (compareHit) begin
            if (streakQ != STREAK_MAX) begin
               streakD = streakQ + 1'b1;
            end
            matchD = (streakD == STREAK_MAX);
         end else begin
            streakD = '0;
            matchD  = 1'b0;
         end
      end

      if (bus.LoadThreshold) begin
         thresholdD = bus.ThresholdIn;
         streakD    = '0;
         matchD     = 1'b0;
      end
   end

   // Count rising edges of the debounced match, sticking at full scale
   always_comb begin
      countD = countQ;
      if (matchD && !matchQ && (countQ != CNT_MAX)) begin
         countD = countQ + 1'b1;
      end
   end

   always_comb begin
      decodedD = '0;
      if (bus.Enable) begin
         decodedD = DEC_W'(1) << bus.Sel;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         thresholdQ <= THR_RESET;
         streakQ    <= '0;
         matchRawQ  <= 1'b0;
         matchQ     <= 1'b0;
         countQ     <= '0;
         decodedQ   <= '0;
      end else begin
         thresholdQ <= thresholdD;
         streakQ    <= streakD;
         matchRawQ  <= matchRawD;
         matchQ     <= matchD;
         countQ     <= countD;
         decodedQ   <= decodedD;
      end
   end

   assign bus.MatchRaw   = matchRawQ;
   assign bus.Match      = matchQ;
   assign bus.MatchCount = countQ;
   assign bus.Decoded    = decodedQ;
endmodule

// File: tb/tb_comparador_decodificador_param.sv
// Randomized and directed bench for comparador_decodificador_param, checked
// against a history-based behavioural model of the compare/debounce/decoder rules.
module tb_comparador_decodificador_param;
   localparam int WIDTH     = 6;
   localparam int THR_DEF   = 22;
   localparam int DEBOUNCE  = 4;
   localparam int SEL_BITS  = 3;
   localparam int CNT_WIDTH = 8;
   localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

   logic Clock = 1'b0;
   logic Reset = 1'b1;

   int compareCount = 0;
   int missCount    = 0;

   // Model state: unbounded run of matching valid samples, event total
   int  refThreshold;
   int  refRun;
   bit  refMatch;
   bit  refMatchRaw;
   int  refEvents;
   int  refDecoded;

   comparador_decodificador_param_if #(
      .WIDTH(WIDTH), .SEL_BITS(SEL_BITS), .CNT_WIDTH(CNT_WIDTH)
   ) bus ();

   comparador_decodificador_param #(
      .WIDTH(WIDTH), .THRESH_DEFAULT(THR_DEF), .DEBOUNCE(DEBOUNCE),
      .SEL_BITS(SEL_BITS), .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   always #5 Clock = ~Clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic bit refCompare(int s, int t, int m);
      case (m)
         0:       return s == t;
         1:       return s > t;
         2:       return s < t;
         default: return s >= t;
      endcase
   endfunction

   task automatic modelStep(input bit rst, input bit ld, input int tin, input int smp,
                            input bit vld, input int md, input int sl, input bit en);
      bit hit;
      bit wasMatch;
      if (rst) begin
         refThreshold = THR_DEF;
         refRun       = 0;
         refMatch     = 0;
         refMatchRaw  = 0;
         refEvents    = 0;
         refDecoded   = 0;
         return;
      end
      hit = refCompare(smp, refThreshold, md);
      if (vld) refMatchRaw = hit;
      if (ld) refRun = 0;
      else if (vld) refRun = hit ? refRun + 1 : 0;
      wasMatch = refMatch;
      refMatch = (refRun >= DEBOUNCE);
      if (refMatch && !wasMatch) refEvents++;
      if (ld) refThreshold = tin;
      refDecoded = en ? (1 << sl) : 0;
   endtask

   task automatic checkAll();
      int expCount;
      expCount = (refEvents > CNT_MAX) ? CNT_MAX : refEvents;
      checkOutput("MatchRaw",   32'(bus.MatchRaw),   32'(refMatchRaw));
      checkOutput("Match",      32'(bus.Match),      32'(refMatch));
      checkOutput("MatchCount", 32'(bus.MatchCount), 32'(expCount));
      checkOutput("Decoded",    32'(bus.Decoded),    32'(refDecoded));
   endtask

   // One clock: drive inputs, advance the model at the edge, check #1 later
   task automatic applyStimulus(input bit rst, input bit ld, input int tin, input int smp,
                                input bit vld, input int md, input int sl, input bit en);
      Reset             = rst;
      bus.LoadThreshold = ld;
      bus.ThresholdIn   = WIDTH'(tin);
      bus.Sample        = WIDTH'(smp);
      bus.SampleValid   = vld;
      bus.Mode          = 2'(md);
      bus.Sel           = SEL_BITS'(sl);
      bus.Enable        = en;
      @(posedge Clock);
      modelStep(rst, ld, tin, smp, vld, md, sl, en);
      #1;
      checkAll();
   endtask

   initial begin
      bus.LoadThreshold = 0; bus.ThresholdIn = '0; bus.Sample = '0;
      bus.SampleValid = 0; bus.Mode = 2'b00; bus.Sel = '0; bus.Enable = 0;

      // Reset state
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

      // Four matches of 22 in EQ mode
      repeat (4) applyStimulus(0, 0, 0, 22, 1, 0, 0, 0);

      // Streak broken after three, then four more
      applyStimulus(0, 0, 0, 21, 1, 0, 0, 0);
      repeat (3) applyStimulus(0, 0, 0, 22, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 21, 1, 0, 0, 0);
      repeat (4) applyStimulus(0, 0, 0, 22, 1, 0, 0, 0);

      // Gaps inside a streak; invalid sample values ignored
      applyStimulus(0, 0, 0, 5, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 22, 1, 0, 0, 0);
         applyStimulus(0, 0, 0, 3 + i, 0, 0, 0, 0);
      end

      // Threshold load while matching, GE mode
      repeat (4) applyStimulus(0, 0, 0, 30, 1, 3, 0, 0);
      applyStimulus(0, 1, 40, 30, 1, 3, 0, 0);
      applyStimulus(0, 0, 0, 30, 1, 3, 0, 0);
      applyStimulus(0, 1, 22, 0, 0, 0, 0, 0);

      // Decoder sweep and disable
      for (int s = 0; s < 8; s++) applyStimulus(0, 0, 0, 0, 0, 0, s, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);

      // Saturate the event counter
      for (int e = 0; e < 260; e++) begin
         repeat (DEBOUNCE) applyStimulus(0, 0, 0, 22, 1, 0, e % 8, 1);
         applyStimulus(0, 0, 0, 21, 1, 0, 0, 0);
      end

      // Reset mid-streak, then confirm threshold is back at the default
      repeat (2) applyStimulus(0, 0, 0, 22, 1, 0, 0, 1);
      applyStimulus(1, 0, 0, 22, 1, 0, 0, 1);
      repeat (4) applyStimulus(0, 0, 0, 22, 1, 0, 0, 0);

      // Random traffic biased around the threshold
      for (int i = 0; i < 3000; i++) begin
         bit rst, ld, vld, en;
         int smp, tin, md, sl;
         rst = ($urandom_range(99) < 2);
         ld  = ($urandom_range(99) < 5);
         vld = ($urandom_range(99) < 75);
         en  = ($urandom_range(99) < 70);
         md  = $urandom_range(3);
         sl  = $urandom_range(7);
         tin = $urandom_range(63);
         if ($urandom_range(1) == 1) smp = refThreshold + $urandom_range(2) - 1;
         else                        smp = $urandom_range(63);
         if (smp < 0)  smp = 0;
         if (smp > 63) smp = 63;
         applyStimulus(rst, ld, tin, smp, vld, md, sl, en);
      end

      $display("== %0d vectors applied, %0d miscompares ==", compareCount, missCount);
      $finish;
   end
endmodule
